tvm_vpi_ram_read_arbiter: RTL and testbench

Two-client read arbiter and sequencer for the VPI-simulated RAM read channel. Two independent requesters each post a read burst (address, word count). The block grants one burst at a time, round-robin, and issues the burst to the RAM control port. It then routes the RAM read stream to the granted client with per-word back-pressure, and signals burst completion. It sits between DMA-style clients and the RAM's `ctrl_read_*` / `out_read_*` / `in_read_dequeue` ports.

---
 rtl/tvm_vpi_ram_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_tvm_vpi_ram_read_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tvm_vpi_ram_read_arbiter.sv
// Two-client round-robin read arbiter for the VPI RAM read channel.
// Grants one burst at a time, issues it to the RAM, then streams words to the winner.
module tvm_vpi_ram_read_arbiter #(
   parameter int READ_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c0_req,
   input  logic [31:0]           c0_addr,
   input  logic [31:0]           c0_size,
   output logic                  c0_ack,
   output logic [READ_WIDTH-1:0] c0_data,
   output logic                  c0_valid,
   input  logic                  c0_ready,
   output logic                  c0_done,
   input  logic                  c1_req,
   input  logic [31:0]           c1_addr,
   input  logic [31:0]           c1_size,
   output logic                  c1_ack,
   output logic [READ_WIDTH-1:0] c1_data,
   output logic                  c1_valid,
   input  logic                  c1_ready,
   output logic                  c1_done,
   output logic                  ram_read_req,
   output logic [31:0]           ram_read_addr,
   output logic [31:0]           ram_read_size,
   output logic                  ram_read_dequeue,
   input  logic [READ_WIDTH-1:0] ram_read_data,
   input  logic                  ram_read_valid,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic        grant, grant_nxt;
   logic        last_grant, last_grant_nxt;
   logic [31:0] count, count_nxt;
   logic [31:0] addr_nxt, size_nxt;
   logic        c0_ack_nxt, c1_ack_nxt;
   logic        c0_done_nxt, c1_done_nxt;
   logic        req_nxt, busy_nxt;
   logic        win;
   logic        streaming;
   logic        sel_ready;

   // On a tie the client that did not win last time goes first.
   assign win = (c0_req && c1_req) ? ~last_grant : c1_req;

   assign streaming        = (state == S_STREAM);
   assign sel_ready        = grant ? c1_ready : c0_ready;
   assign ram_read_dequeue = streaming & ram_read_valid & sel_ready;
   assign c0_valid         = streaming & ram_read_valid & ~grant;
   assign c1_valid         = streaming & ram_read_valid & grant;
   assign c0_data          = ram_read_data;
   assign c1_data          = ram_read_data;

   always_comb begin
      // NOTE: every signal written here is defaulted first so no path can infer a latch.
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      count_nxt      = count;
      addr_nxt       = ram_read_addr;
      size_nxt       = ram_read_size;
      c0_ack_nxt     = 1'b0;
      c1_ack_nxt     = 1'b0;
      c0_done_nxt    = 1'b0;
      c1_done_nxt    = 1'b0;
      req_nxt        = 1'b0;

      case (state)
         S_IDLE: begin
            if (c0_req || c1_req) begin
               grant_nxt      = win;
               last_grant_nxt = win;
               count_nxt      = 32'd0;
               addr_nxt       = win ? c1_addr : c0_addr;
               size_nxt       = win ? c1_size : c0_size;
               c0_ack_nxt     = ~win;
               c1_ack_nxt     = win;
               state_nxt      = (size_nxt == 32'd0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            req_nxt   = 1'b1;
            state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (ram_read_dequeue) begin
               count_nxt = count + 32'd1;
               if (count == ram_read_size - 32'd1) begin
                  c0_done_nxt = ~grant;
                  c1_done_nxt = grant;
                  state_nxt   = S_DONE;
               end
            end
         end
         S_DONE: begin
            // A zero-size burst reaches DONE without a pulse; raise it on the way out.
            if (!(c0_done || c1_done)) begin
               c0_done_nxt = ~grant;
               c1_done_nxt = grant;
            end
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         grant         <= 1'b0;
         last_grant    <= 1'b1;
         count         <= 32'd0;
         ram_read_addr <= 32'd0;
         ram_read_size <= 32'd0;
         ram_read_req  <= 1'b0;
         c0_ack        <= 1'b0;
         c1_ack        <= 1'b0;
         c0_done       <= 1'b0;
         c1_done       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         grant         <= grant_nxt;
         last_grant    <= last_grant_nxt;
         count         <= count_nxt;
         ram_read_addr <= addr_nxt;
         ram_read_size <= size_nxt;
         ram_read_req  <= req_nxt;
         c0_ack        <= c0_ack_nxt;
         c1_ack        <= c1_ack_nxt;
         c0_done       <= c0_done_nxt;
         c1_done       <= c1_done_nxt;
         busy          <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_tvm_vpi_ram_read_arbiter.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_tvm_vpi_ram_read_arbiter;

   typedef enum int {EV_ACK, EV_REQ, EV_WORD, EV_DONE} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      int          client;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_req, c1_req;
   logic [31:0] c0_addr, c0_size, c1_addr, c1_size;
   logic        c0_ack, c1_ack, c0_valid, c1_valid, c0_done, c1_done;
   logic        c0_ready, c1_ready;
   logic [7:0]  c0_data, c1_data;
   logic        ram_read_req, ram_read_dequeue, ram_read_valid, busy;
   logic [31:0] ram_read_addr, ram_read_size;
   logic [7:0]  ram_read_data;

   ev_t         exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_ack_cyc = 0, last_word_cyc = 0, burst_words = 0;
   int          cur_client = 0;
   int          words_seen = 0;
   int          c0_acks = 0, c1_acks = 0;
   logic        prev_c0_ack = 0, prev_c1_ack = 0, prev_c0_done = 0, prev_c1_done = 0;
   logic [31:0] ram_ptr = 32'd0;

   tvm_vpi_ram_read_arbiter #(.READ_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_size(c0_size), .c0_ack(c0_ack),
      .c0_data(c0_data), .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_done(c0_done),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_size(c1_size), .c1_ack(c1_ack),
      .c1_data(c1_data), .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_done(c1_done),
      .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr), .ram_read_size(ram_read_size),
      .ram_read_dequeue(ram_read_dequeue), .ram_read_data(ram_read_data),
      .ram_read_valid(ram_read_valid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: word i of a burst carries the low byte of (addr + i).
   always @(posedge clk) begin
      if (ram_read_req && ram_read_dequeue) ram_ptr <= ram_read_addr + 32'd1;
      else if (ram_read_req)                ram_ptr <= ram_read_addr;
      else if (ram_read_dequeue)            ram_ptr <= ram_ptr + 32'd1;
   end
   assign ram_read_data = ram_read_req ? ram_read_addr[7:0] : ram_ptr[7:0];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input ev_kind_t k, input int cl, input logic [31:0] a,
                          input logic [31:0] b, input int c);
      exp_q.push_back('{kind: k, client: cl, a: a, b: b, cyc: c});
   endtask

   task automatic expect_burst(input int cl, input logic [31:0] addr, input logic [31:0] size,
                               input int ack_cyc);
      push_ev(EV_ACK, cl, 32'd0, 32'd0, ack_cyc);
      if (size != 32'd0) begin
         push_ev(EV_REQ, cl, addr, size, (ack_cyc < 0) ? -1 : ack_cyc + 1);
         for (int i = 0; i < int'(size); i++)
            push_ev(EV_WORD, cl, (addr + 32'(i)) & 32'hFF, 32'd0, (ack_cyc < 0) ? -1 : ack_cyc + 1 + i);
      end
      push_ev(EV_DONE, cl, 32'd0, 32'd0, -1);
   endtask

   task automatic observe(input ev_kind_t k, input int cl, input logic [31:0] a, input logic [31:0] b);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_event: got %s client %0d a=%0h b=%0h at cycle %0d, expected nothing",
                  k.name(), cl, a, b, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.client != cl || e.a !== a || e.b !== b) begin
            n_bad++;
            $display("FAIL event: got %s c%0d a=%0h b=%0h, expected %s c%0d a=%0h b=%0h (cycle %0d)",
                     k.name(), cl, a, b, e.kind.name(), e.client, e.a, e.b, cyc);
         end
         if (e.cyc >= 0) check("event_cycle", 64'(cyc), 64'(e.cyc));
      end
      case (k)
         EV_ACK: begin
            last_ack_cyc = cyc;
            burst_words  = 0;
            cur_client   = cl;
            if (cl == 0) c0_acks++; else c1_acks++;
         end
         EV_REQ:  check("req_after_ack", 64'(cyc), 64'(last_ack_cyc + 1));
         EV_WORD: begin
            last_word_cyc = cyc;
            burst_words++;
            words_seen++;
         end
         EV_DONE: check("done_timing", 64'(cyc),
                        64'((burst_words > 0) ? last_word_cyc + 1 : last_ack_cyc + 1));
         default: ;
      endcase
   endtask

   // Monitor: events are taken in a fixed per-cycle order: ack, req, word, done.
   always @(negedge clk) begin
      if (rst) begin
         if (c0_ack) begin check("c0_ack_width", 64'(prev_c0_ack), 64'd0); observe(EV_ACK, 0, 32'd0, 32'd0); end
         if (c1_ack) begin check("c1_ack_width", 64'(prev_c1_ack), 64'd0); observe(EV_ACK, 1, 32'd0, 32'd0); end
         if (ram_read_req) observe(EV_REQ, cur_client, ram_read_addr, ram_read_size);
         if (c0_valid || c1_valid)
            check("valid_owner", {62'd0, c0_valid, c1_valid}, (cur_client == 0) ? 64'd2 : 64'd1);
         check("dequeue_rule", 64'(ram_read_dequeue),
               64'((c0_valid & c0_ready) | (c1_valid & c1_ready)));
         if (ram_read_dequeue)
            observe(EV_WORD, c1_valid ? 1 : 0, {24'd0, c1_valid ? c1_data : c0_data}, 32'd0);
         if (c0_done) begin check("c0_done_width", 64'(prev_c0_done), 64'd0); observe(EV_DONE, 0, 32'd0, 32'd0); end
         if (c1_done) begin check("c1_done_width", 64'(prev_c1_done), 64'd0); observe(EV_DONE, 1, 32'd0, 32'd0); end
         prev_c0_ack  = c0_ack;
         prev_c1_ack  = c1_ack;
         prev_c0_done = c0_done;
         prev_c1_done = c1_done;
      end else begin
         prev_c0_ack  = 1'b0;
         prev_c1_ack  = 1'b0;
         prev_c0_done = 1'b0;
         prev_c1_done = 1'b0;
      end
   end

   task automatic post(input int cl, input logic [31:0] addr, input logic [31:0] size);
      if (cl == 0) begin c0_addr = addr; c0_size = size; c0_req = 1'b1; end
      else         begin c1_addr = addr; c1_size = size; c1_req = 1'b1; end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((cl == 0 && c0_ack) || (cl == 1 && c1_ack)) begin
            if (cl == 0) c0_req = 1'b0; else c1_req = 1'b0;
            return;
         end
      end
      if (cl == 0) c0_req = 1'b0; else c1_req = 1'b0;
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: client %0d saw no ack within 300 cycles", cl);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (!busy && exp_q.size() == 0) break;
      end
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {53'd0, c0_ack, c1_ack, c0_done, c1_done, c0_valid, c1_valid,
                   ram_read_req, ram_read_dequeue, busy, 1'b0, 1'b0}, 64'd0);
      check({name, "_addr_size"}, {ram_read_addr, ram_read_size}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int base_words;
      int base_c1_acks;
      logic [4:0] pat;

      rst = 1'b0;
      c0_req = 1'b0; c1_req = 1'b0;
      c0_addr = '0; c0_size = '0; c1_addr = '0; c1_size = '0;
      c0_ready = 1'b1; c1_ready = 1'b1;
      ram_read_valid = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      rst = 1'b1;

      // Tie: both hold requests, grants must alternate c0, c1, c0, c1.
      @(posedge clk); #1;
      expect_burst(0, 32'h200, 32'd2, -1);
      expect_burst(1, 32'h300, 32'd2, -1);
      expect_burst(0, 32'h220, 32'd2, -1);
      expect_burst(1, 32'h320, 32'd2, -1);
      fork
         begin post(0, 32'h200, 32'd2); post(0, 32'h220, 32'd2); end
         begin post(1, 32'h300, 32'd2); post(1, 32'h320, 32'd2); end
      join
      wait_idle();

      // Single burst with exact cycle expectations.
      @(posedge clk); #1;
      t = cyc;
      expect_burst(0, 32'h100, 32'd4, t + 1);
      post(0, 32'h100, 32'd4);
      wait_idle();

      // Back-pressure: ready pattern 1,0,1,0,1 from the first stream cycle.
      @(posedge clk); #1;
      pat = 5'b10101;
      expect_burst(1, 32'h400, 32'd3, -1);
      fork
         post(1, 32'h400, 32'd3);
         begin
            @(posedge clk);
            for (int i = 0; i < 5; i++) begin
               @(posedge clk); #1;
               c1_ready = pat[i];
               @(negedge clk);
               check("bp_dequeue", 64'(ram_read_dequeue), 64'(pat[i]));
            end
            c1_ready = 1'b1;
         end
      join
      wait_idle();

      // Zero-size burst: ack then done, no RAM request.
      @(posedge clk); #1;
      expect_burst(0, 32'h500, 32'd0, cyc + 1);
      post(0, 32'h500, 32'd0);
      wait_idle();

      // Withdrawn request from c1 while c0 streams.
      @(posedge clk); #1;
      base_c1_acks = c1_acks;
      expect_burst(0, 32'h600, 32'd4, -1);
      fork
         post(0, 32'h600, 32'd4);
         begin
            repeat (3) @(posedge clk);
            #1;
            c1_addr = 32'h700; c1_size = 32'd1; c1_req = 1'b1;
            @(posedge clk); #1;
            c1_req = 1'b0;
         end
      join
      wait_idle();
      repeat (3) @(negedge clk);
      check("withdrawn_no_c1_ack", 64'(c1_acks - base_c1_acks), 64'd0);

      // Reset after 2 of 8 words: outputs drop at once, no done afterwards.
      @(posedge clk); #1;
      base_words = words_seen;
      push_ev(EV_ACK, 0, 32'd0, 32'd0, -1);
      push_ev(EV_REQ, 0, 32'h800, 32'd8, -1);
      push_ev(EV_WORD, 0, 32'h00, 32'd0, -1);
      push_ev(EV_WORD, 0, 32'h01, 32'd0, -1);
      post(0, 32'h800, 32'd8);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (words_seen >= base_words + 2) break;
      end
      check("words_before_reset", 64'(words_seen - base_words), 64'd2);
      rst = 1'b0;
      #1;
      check_all_zero("reset_midstream");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("reset_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (4) @(negedge clk);
      check("no_done_after_reset", 64'(exp_q.size()), 64'd0);

      // Tie after reset must go to c0 first.
      @(posedge clk); #1;
      expect_burst(0, 32'h900, 32'd1, -1);
      expect_burst(1, 32'hA00, 32'd1, -1);
      fork
         post(0, 32'h900, 32'd1);
         post(1, 32'hA00, 32'd1);
      join
      wait_idle();

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
